// File: rtl/writeback_commit.sv
// rtl/writeback_commit.sv - in-order commit stage with retire counter and post-jump squash

package wb_pkg;
    typedef logic [63:0] word_t;
    typedef logic [63:0] addr_t;

    typedef struct packed {
        logic       reg_write_enable;
        logic [4:0] reg_dest_addr;
        word_t      reg_write_data;
    } reg_writer;

    typedef struct packed {
        logic  do_jump;
        logic  jump_inst;
        addr_t jump_addr;
        word_t inst_counter;
    } jump_writer;

    typedef struct packed {
        word_t new_csrs;
        word_t csr_write_mask;
    } csr_writer;
endpackage

module writeback_commit #(
    parameter int COUNT_W = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  wb_pkg::reg_writer  in_reg,
    input  wb_pkg::jump_writer in_jump,
    input  wb_pkg::csr_writer  in_csr,
    input  wb_pkg::addr_t      in_pc,
    input  logic               flush_ack,
    output logic               commit_valid,
    output wb_pkg::addr_t      commit_pc,
    output wb_pkg::reg_writer  reg_wb,
    output wb_pkg::jump_writer jump_wb,
    output wb_pkg::csr_writer  csr_wb,
    output logic [COUNT_W-1:0] retire_count
);
    import wb_pkg::*;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // One-entry commit register; only the fields that reach the outputs are kept.
    logic         cap_valid;
    reg_writer    cap_reg;
    logic         cap_do_jump;
    logic         cap_jump_inst;
    addr_t        cap_jump_addr;
    csr_writer    cap_csr;
    addr_t        cap_pc;
    logic [COUNT_W-1:0] count;

    logic transfer;

    // The incoming inst_counter is recomputed here, so its value is deliberately dropped.
    logic unused_in_inst_counter;
    assign unused_in_inst_counter = ^in_jump.inst_counter;

    assign transfer = in_valid && in_ready;

    // Capture an accepted result and bump the retire counter on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_valid     <= 1'b0;
            cap_reg       <= '0;
            cap_do_jump   <= 1'b0;
            cap_jump_inst <= 1'b0;
            cap_jump_addr <= '0;
            cap_csr       <= '0;
            cap_pc        <= '0;
            count         <= '0;
        end else begin
            cap_valid <= transfer;
            if (transfer) begin
                cap_reg       <= in_reg;
                cap_do_jump   <= in_jump.do_jump;
                cap_jump_inst <= in_jump.jump_inst;
                cap_jump_addr <= in_jump.jump_addr;
                cap_csr       <= in_csr;
                cap_pc        <= in_pc;
                count         <= count + 1'b1;
            end
        end
    end

    // State register for the run/squash machine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Enter squash after a committed jump; leave it once fetch confirms the flush.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (cap_valid && cap_do_jump) begin
                    state_next = ST_SQUASH;
                end
            end
            ST_SQUASH: begin
                if (flush_ack) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // Input is accepted only while running.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            ST_RUN:    in_ready = 1'b1;
            ST_SQUASH: in_ready = 1'b0;
            default:   in_ready = 1'b1;
        endcase
    end

    // Broadcast the captured entry; side-effecting strobes are gated by commit_valid.
    always_comb begin
        commit_valid = cap_valid;
        commit_pc    = cap_pc;

        reg_wb                  = cap_reg;
        reg_wb.reg_write_enable = cap_valid && cap_reg.reg_write_enable
                                  && (cap_reg.reg_dest_addr != 5'd0);

        jump_wb.do_jump      = cap_valid && cap_do_jump;
        jump_wb.jump_inst    = cap_valid && cap_jump_inst;
        jump_wb.jump_addr    = cap_jump_addr;
        jump_wb.inst_counter = word_t'(count);

        csr_wb.new_csrs       = cap_csr.new_csrs;
        csr_wb.csr_write_mask = cap_valid ? cap_csr.csr_write_mask : '0;

        retire_count = count;
    end

endmodule

// File: tb/tb_writeback_commit.sv
// tb/tb_writeback_commit.sv - directed self-checking bench for writeback_commit

module tb_writeback_commit;
    import wb_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    reg_writer  in_reg;
    jump_writer in_jump;
    csr_writer  in_csr;
    addr_t      in_pc;
    logic       flush_ack;
    logic       commit_valid;
    addr_t      commit_pc;
    reg_writer  reg_wb;
    jump_writer jump_wb;
    csr_writer  csr_wb;
    logic [63:0] retire_count;

    logic       in_ready_s;
    logic       commit_valid_s;
    addr_t      commit_pc_s;
    reg_writer  reg_wb_s;
    jump_writer jump_wb_s;
    csr_writer  csr_wb_s;
    logic [2:0] retire_count_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    writeback_commit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_reg(in_reg), .in_jump(in_jump), .in_csr(in_csr), .in_pc(in_pc),
        .flush_ack(flush_ack), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .reg_wb(reg_wb), .jump_wb(jump_wb), .csr_wb(csr_wb), .retire_count(retire_count)
    );

    // Narrow counter copy so wraparound is reachable in a few commits.
    writeback_commit #(.COUNT_W(3)) dut_small (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_reg(in_reg), .in_jump(in_jump), .in_csr(in_csr), .in_pc(in_pc),
        .flush_ack(flush_ack), .commit_valid(commit_valid_s), .commit_pc(commit_pc_s),
        .reg_wb(reg_wb_s), .jump_wb(jump_wb_s), .csr_wb(csr_wb_s),
        .retire_count(retire_count_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; flush_ack = 1'b0;
        in_reg = '0; in_jump = '0; in_csr = '0; in_pc = '0;
        #1;
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL rst_cv got %0b want 0", commit_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %0b want 1", in_ready); end
        n_cmp++; if (retire_count !== 64'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", retire_count); end
        n_cmp++; if (reg_wb !== reg_writer'(0) || jump_wb !== jump_writer'(0) || csr_wb !== csr_writer'(0) || commit_pc !== 64'd0) begin
            n_err++; $display("FAIL rst_outputs got reg=%h jump=%h csr=%h pc=%h want all 0", reg_wb, jump_wb, csr_wb, commit_pc);
        end
        #9;
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_reg = '{1'b1, 5'd5, 64'h11}; in_pc = 64'h100;
        tick();
        in_reg = '{1'b1, 5'd6, 64'h22}; in_pc = 64'h104;
        n_cmp++; if (commit_valid !== 1'b1) begin n_err++; $display("FAIL b2b_cv1 got %0b want 1", commit_valid); end
        n_cmp++; if (reg_wb !== reg_writer'{1'b1, 5'd5, 64'h11}) begin n_err++; $display("FAIL b2b_reg1 got %h want en=1 x5 0x11", reg_wb); end
        n_cmp++; if (commit_pc !== 64'h100) begin n_err++; $display("FAIL b2b_pc1 got %h want 100", commit_pc); end
        n_cmp++; if (retire_count !== 64'd1 || jump_wb.inst_counter !== 64'd1) begin n_err++; $display("FAIL b2b_cnt1 got %0d/%0d want 1/1", retire_count, jump_wb.inst_counter); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (commit_valid !== 1'b1) begin n_err++; $display("FAIL b2b_cv2 got %0b want 1", commit_valid); end
        n_cmp++; if (reg_wb !== reg_writer'{1'b1, 5'd6, 64'h22}) begin n_err++; $display("FAIL b2b_reg2 got %h want en=1 x6 0x22", reg_wb); end
        n_cmp++; if (retire_count !== 64'd2) begin n_err++; $display("FAIL b2b_cnt2 got %0d want 2", retire_count); end
        tick();
        n_cmp++; if (commit_valid !== 1'b0 || reg_wb.reg_write_enable !== 1'b0) begin n_err++; $display("FAIL b2b_idle got cv=%0b en=%0b want 0/0", commit_valid, reg_wb.reg_write_enable); end
        n_cmp++; if (reg_wb.reg_write_data !== 64'h22 || retire_count !== 64'd2) begin n_err++; $display("FAIL b2b_hold got data=%h cnt=%0d want 22/2", reg_wb.reg_write_data, retire_count); end
    endtask

    task automatic test_x0();
        in_valid = 1'b1; in_reg = '{1'b1, 5'd0, 64'hdead}; in_pc = 64'h108;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (commit_valid !== 1'b1) begin n_err++; $display("FAIL x0_cv got %0b want 1", commit_valid); end
        n_cmp++; if (reg_wb.reg_write_enable !== 1'b0) begin n_err++; $display("FAIL x0_en got %0b want 0", reg_wb.reg_write_enable); end
        n_cmp++; if (reg_wb.reg_write_data !== 64'hdead) begin n_err++; $display("FAIL x0_data got %h want dead", reg_wb.reg_write_data); end
        n_cmp++; if (retire_count !== 64'd3) begin n_err++; $display("FAIL x0_cnt got %0d want 3", retire_count); end
        tick();
    endtask

    task automatic test_jal();
        in_valid = 1'b1; in_reg = '{1'b1, 5'd1, 64'h8000_0004};
        in_jump = '{1'b1, 1'b1, 64'h8000_0100, 64'hffff}; in_pc = 64'h8000_0000;
        tick();
        in_valid = 1'b0; in_jump = '0;
        n_cmp++; if (jump_wb.do_jump !== 1'b1 || jump_wb.jump_inst !== 1'b1 || jump_wb.jump_addr !== 64'h8000_0100) begin
            n_err++; $display("FAIL jal_jump got dj=%0b ji=%0b addr=%h want 1/1/80000100", jump_wb.do_jump, jump_wb.jump_inst, jump_wb.jump_addr);
        end
        n_cmp++; if (reg_wb !== reg_writer'{1'b1, 5'd1, 64'h8000_0004}) begin n_err++; $display("FAIL jal_link got %h want en=1 x1 80000004", reg_wb); end
        n_cmp++; if (jump_wb.inst_counter !== 64'd4 || retire_count !== 64'd4) begin n_err++; $display("FAIL jal_cnt got %0d/%0d want 4/4", jump_wb.inst_counter, retire_count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL jal_ready_commit got %0b want 1", in_ready); end
        tick();
        n_cmp++; if (in_ready !== 1'b0 || jump_wb.do_jump !== 1'b0) begin n_err++; $display("FAIL jal_sq1 got rdy=%0b dj=%0b want 0/0", in_ready, jump_wb.do_jump); end
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL jal_sq2 got %0b want 0", in_ready); end
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL jal_sq3 got %0b want 0", in_ready); end
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL jal_resume got %0b want 1", in_ready); end
    endtask

    task automatic test_mret();
        in_valid = 1'b1; in_reg = '0; in_jump = '{1'b1, 1'b0, 64'h8000_0200, 64'd0};
        in_csr = '{64'h1234, 64'h8}; in_pc = 64'h9000;
        tick();
        in_valid = 1'b0; in_jump = '0; in_csr = '0;
        flush_ack = 1'b1;
        n_cmp++; if (jump_wb.do_jump !== 1'b1 || csr_wb.csr_write_mask !== 64'h8 || csr_wb.new_csrs !== 64'h1234) begin
            n_err++; $display("FAIL mret_issue got dj=%0b mask=%h csrs=%h want 1/8/1234", jump_wb.do_jump, csr_wb.csr_write_mask, csr_wb.new_csrs);
        end
        n_cmp++; if (jump_wb.inst_counter !== 64'd5 || retire_count !== 64'd5) begin n_err++; $display("FAIL mret_cnt got %0d/%0d want 5/5", jump_wb.inst_counter, retire_count); end
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mret_sq got %0b want 0", in_ready); end
        n_cmp++; if (csr_wb.csr_write_mask !== 64'd0 || csr_wb.new_csrs !== 64'h1234) begin n_err++; $display("FAIL mret_gate got mask=%h csrs=%h want 0/1234", csr_wb.csr_write_mask, csr_wb.new_csrs); end
        tick();
        flush_ack = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mret_resume got %0b want 1", in_ready); end
    endtask

    task automatic test_wrap();
        in_valid = 1'b1; in_reg = '{1'b1, 5'd9, 64'h99}; in_pc = 64'ha000;
        tick();
        n_cmp++; if (retire_count_s !== 3'd6) begin n_err++; $display("FAIL wrap_c6 got %0d want 6", retire_count_s); end
        tick();
        n_cmp++; if (retire_count_s !== 3'd7) begin n_err++; $display("FAIL wrap_c7 got %0d want 7", retire_count_s); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (commit_valid_s !== 1'b1 || retire_count_s !== 3'd0 || jump_wb_s.inst_counter !== 64'd0) begin
            n_err++; $display("FAIL wrap_zero got cv=%0b cnt=%0d ic=%0d want 1/0/0", commit_valid_s, retire_count_s, jump_wb_s.inst_counter);
        end
        n_cmp++; if (retire_count !== 64'd8 || jump_wb.inst_counter !== 64'd8) begin n_err++; $display("FAIL wrap_wide got %0d/%0d want 8/8", retire_count, jump_wb.inst_counter); end
        tick();
    endtask

    task automatic test_reset_squash();
        in_valid = 1'b1; in_reg = '0; in_jump = '{1'b1, 1'b1, 64'h300, 64'd0}; in_pc = 64'h2fc;
        tick();
        in_jump = '0; in_reg = '{1'b1, 5'd7, 64'h77}; in_pc = 64'h300;
        n_cmp++; if (jump_wb.do_jump !== 1'b1 || retire_count !== 64'd9) begin n_err++; $display("FAIL succ_jump got dj=%0b cnt=%0d want 1/9", jump_wb.do_jump, retire_count); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (commit_valid !== 1'b1 || reg_wb !== reg_writer'{1'b1, 5'd7, 64'h77} || jump_wb.do_jump !== 1'b0) begin
            n_err++; $display("FAIL succ_commit got cv=%0b reg=%h dj=%0b want 1/en x7 77/0", commit_valid, reg_wb, jump_wb.do_jump);
        end
        n_cmp++; if (in_ready !== 1'b0 || retire_count !== 64'd10) begin n_err++; $display("FAIL succ_sq got rdy=%0b cnt=%0d want 0/10", in_ready, retire_count); end
        reset = 1'b1;
        #1;
        n_cmp++; if (commit_valid !== 1'b0 || in_ready !== 1'b1 || retire_count !== 64'd0) begin
            n_err++; $display("FAIL arst_ctl got cv=%0b rdy=%0b cnt=%0d want 0/1/0", commit_valid, in_ready, retire_count);
        end
        n_cmp++; if (reg_wb !== reg_writer'(0) || jump_wb !== jump_writer'(0) || csr_wb !== csr_writer'(0) || commit_pc !== 64'd0) begin
            n_err++; $display("FAIL arst_outputs got reg=%h jump=%h csr=%h pc=%h want all 0", reg_wb, jump_wb, csr_wb, commit_pc);
        end
        #2;
        reset = 1'b0;
        tick();
        n_cmp++; if (commit_valid !== 1'b0 || retire_count !== 64'd0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL arst_after got cv=%0b cnt=%0d rdy=%0b want 0/0/1", commit_valid, retire_count, in_ready);
        end
        in_valid = 1'b1; in_reg = '{1'b1, 5'd3, 64'h33}; in_pc = 64'h400;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (commit_valid !== 1'b1 || retire_count !== 64'd1 || reg_wb !== reg_writer'{1'b1, 5'd3, 64'h33}) begin
            n_err++; $display("FAIL arst_restart got cv=%0b cnt=%0d reg=%h want 1/1/en x3 33", commit_valid, retire_count, reg_wb);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_x0();
        test_jal();
        test_mret();
        test_wrap();
        test_reset_squash();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/writeback_commit.md
# writeback_commit

Final in-order commit stage of the core pipeline. It accepts one memory-stage result per cycle over a valid/ready handshake, registers it, and in the following cycle broadcasts it as a `reg_writer` to the register file, a `csr_writer` to the CSR file and a `jump_writer` to fetch. It also maintains the 64-bit retired-instruction counter. After a taken jump it holds off new input until fetch acknowledges the flush.

## Interface
Parameters:
- `COUNT_W`, default 64: width of the retire counter; matches `word_t`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream holds a result.
- `in_ready`  out  1  stage can accept a result this cycle.
- `in_reg`  in  `reg_writer`  register write request.
- `in_jump`  in  `jump_writer`  jump request; its `inst_counter` field is ignored on input.
- `in_csr`  in  `csr_writer`  CSR write request.
- `in_pc`  in  `addr_t`  PC of the result.
- `flush_ack`  in  1  fetch has flushed after a redirect.
- `commit_valid`  out  1  one instruction retires this cycle.
- `commit_pc`  out  `addr_t`  PC of the retiring instruction.
- `reg_wb`  out  `reg_writer`  to register file and bypass network.
- `jump_wb`  out  `jump_writer`  redirect to fetch.
- `csr_wb`  out  `csr_writer`  to CSR file.
- `retire_count`  out  `COUNT_W`  total retired instructions.

## Operation
- Handshake: a transfer occurs when `in_valid && in_ready` at a rising edge. The transferred fields are captured into a one-entry commit register.
- `commit_valid` is 1 exactly in the cycle after a transfer, otherwise 0. There is no downstream backpressure.
- Output gating: when `commit_valid` = 0, `reg_wb.reg_write_enable`, `jump_wb.do_jump`, `jump_wb.jump_inst` and `csr_wb.csr_write_mask` are all 0. All other output fields hold their last values.
- x0 suppression: `reg_wb.reg_write_enable` is forced to 0 when the captured `reg_dest_addr` is 0. `reg_write_data` passes through unchanged.
- CSR write: `csr_wb` carries the captured `new_csrs` and `csr_write_mask` unchanged. A nonzero mask while `commit_valid` = 1 constitutes the write.
- Retire counter: increments by 1 in the same edge that drives `commit_valid` to 1. It wraps from all-ones to 0.
- `jump_wb.inst_counter` equals the counter value that includes the retiring instruction, i.e. `retire_count` as visible during the commit cycle. This applies to every commit, not only jumps.
- State machine, two states:
  - RUN: `in_ready` = 1.
  - SQUASH: `in_ready` = 0.
  - RUN → SQUASH: at the edge ending a commit cycle whose `jump_wb.do_jump` = 1.
  - SQUASH → RUN: at the first edge where `flush_ack` = 1.
  - `flush_ack` is ignored in RUN.
- Simultaneous events:
  - `do_jump` with a nonzero CSR mask (trap return): both are issued in the same commit cycle.
  - `do_jump` with a register write (JAL/JALR link): the register write is also issued.
  - A transfer accepted in the same cycle that a jump commits is legal. It is the jump's delay-slot-free successor and must be flushed upstream; this block still commits it. Upstream therefore deasserts `in_valid` in the cycle after it sends a taken jump.

## Timing
- Latency: 1 cycle from transfer to commit. Throughput: 1 instruction per cycle in RUN.
- Redirect: `do_jump` is high for exactly 1 cycle per taken jump.
- `in_ready` is low from the cycle after the jump commit until the cycle after `flush_ack` is sampled. Minimum bubble is 1 cycle (when `flush_ack` = 1 in the first SQUASH cycle).
- Reset, asynchronous at any point, including mid-SQUASH or mid-commit. Outputs take these values immediately:
  - `commit_valid` = 0, `in_ready` = 1 (state RUN), `retire_count` = 0.
  - `reg_wb`, `jump_wb`, `csr_wb` and `commit_pc` all zero.
  - A pending captured entry is discarded.
- After reset deasserts, the first transfer is allowed at the first rising edge.

## Test plan
- Back-to-back ALU results: x5 ← 0x11, x6 ← 0x22 on consecutive cycles → `commit_valid` high for 2 cycles, `reg_wb` matches each one cycle late, `retire_count` goes 1 then 2.
- Write to x0 with data 0xdead → `commit_valid` = 1, `reg_wb.reg_write_enable` = 0, counter increments.
- Taken JAL to 0x8000_0100 with link x1 ← 0x8000_0004 → `do_jump` = 1 for one cycle, x1 written in the same cycle, `in_ready` = 0 next cycle. `flush_ack` pulsed 3 cycles later → `in_ready` returns to 1 on the following cycle.
- mret-style commit: `do_jump` = 1 with a nonzero CSR mask → `csr_wb` mask nonzero and `do_jump` = 1 in the same cycle, `inst_counter` equals `retire_count`.
- Counter wrap: preload via 2^64−1 commits (or force) → next commit gives `retire_count` = 0 and `inst_counter` = 0.
- `reset` asserted mid-SQUASH with an entry captured → all outputs 0 and `in_ready` = 1 asynchronously, no commit after release, counter restarts from 0.
